// File: rtl/mux_stream_nto1.sv
// Registered N-to-1 stream multiplexer with valid/ready handshakes on every channel.
// The channel is chosen either by an external select or by round-robin arbitration.
module mux_stream_nto1 #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mode,
    input  logic [SW-1:0]   i_sel,
    input  logic [N*W-1:0]  i_in_data,
    input  logic [N-1:0]    i_in_valid,
    output logic [N-1:0]    o_in_ready,
    output logic [W-1:0]    o_out_data,
    output logic [SW-1:0]   o_out_chan,
    output logic            o_out_valid,
    input  logic            i_out_ready
);

    logic            r_valid;
    logic [W-1:0]    r_data;
    logic [SW-1:0]   r_chan;
    logic [SW-1:0]   r_ptr;

    logic            w_ld;
    logic            w_gnt_vld;
    logic [SW-1:0]   w_gnt;
    logic            w_xfer;
    logic [W-1:0]    w_data;
    logic [SW-1:0]   w_cand;
    int unsigned     w_idx;

    assign w_ld   = !r_valid || i_out_ready;
    assign w_xfer = w_ld && w_gnt_vld && !i_rst;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_cand    = '0;
        w_idx     = 0;
        if (!i_mode) begin
            // An out-of-range select matches no channel and so yields no grant.
            for (int unsigned k = 0; k < N; k++) begin
                if (i_sel == SW'(k) && i_in_valid[k]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SW'(k);
                end
            end
        end else begin
            // Search ptr+1 .. ptr+N (mod N); the first valid candidate wins.
            for (int unsigned i = 1; i <= N; i++) begin
                w_idx  = (32'(r_ptr) + i) % N;
                w_cand = SW'(w_idx);
                for (int unsigned k = 0; k < N; k++) begin
                    if (!w_gnt_vld && w_cand == SW'(k) && i_in_valid[k]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt     = SW'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (w_gnt == SW'(k)) begin
                w_data = i_in_data[k*W +: W];
            end
        end
    end

    always_comb begin
        o_in_ready = '0;
        for (int unsigned k = 0; k < N; k++) begin
            o_in_ready[k] = w_xfer && (w_gnt == SW'(k));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= SW'(N - 1);
        end else if (w_ld) begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_chan  <= w_gnt;
                r_ptr   <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_chan  = r_chan;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Directed bench for mux_stream_nto1: a 4-channel and a 3-channel instance,
// each stepped through hand-computed vectors.
module tb_mux_stream_nto1;

    logic        clk;
    int          n_checks;
    int          n_fail;

    // 4-channel instance
    logic        rst4;
    logic        mode4;
    logic [1:0]  sel4;
    logic [31:0] data4;
    logic [3:0]  valid4;
    logic [3:0]  ready4;
    logic [7:0]  odata4;
    logic [1:0]  ochan4;
    logic        ovalid4;
    logic        oready4;

    // 3-channel instance
    logic        rst3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] data3;
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic [7:0]  odata3;
    logic [1:0]  ochan3;
    logic        ovalid3;
    logic        oready3;

    mux_stream_nto1 #(.N(4), .W(8)) u_dut4 (
        .i_clk       (clk),
        .i_rst       (rst4),
        .i_mode      (mode4),
        .i_sel       (sel4),
        .i_in_data   (data4),
        .i_in_valid  (valid4),
        .o_in_ready  (ready4),
        .o_out_data  (odata4),
        .o_out_chan  (ochan4),
        .o_out_valid (ovalid4),
        .i_out_ready (oready4)
    );

    mux_stream_nto1 #(.N(3), .W(8)) u_dut3 (
        .i_clk       (clk),
        .i_rst       (rst3),
        .i_mode      (mode3),
        .i_sel       (sel3),
        .i_in_data   (data3),
        .i_in_valid  (valid3),
        .o_in_ready  (ready3),
        .o_out_data  (odata3),
        .o_out_chan  (ochan3),
        .o_out_valid (ovalid3),
        .i_out_ready (oready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_data [4];
        logic [1:0] exp_chan [4];
        n_checks = 0;
        n_fail   = 0;
        exp_data = '{8'h11, 8'h22, 8'hA5, 8'h44};

        rst4    = 1'b1;
        mode4   = 1'b0;
        sel4    = 2'd0;
        data4   = {8'h44, 8'hA5, 8'h22, 8'h11};
        valid4  = 4'b1111;
        oready4 = 1'b1;
        rst3    = 1'b1;
        mode3   = 1'b0;
        sel3    = 2'd0;
        data3   = {8'h33, 8'h32, 8'h31};
        valid3  = 3'b111;
        oready3 = 1'b1;

        // Reset held for two cycles with every channel valid
        #1;
        check("rst_ready_pre", 32'(ready4), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready", 32'(ready4), 32'h0);
            check("rst_valid", 32'(ovalid4), 32'h0);
            check("rst_data", 32'(odata4), 32'h0);
            check("rst_chan", 32'(ochan4), 32'h0);
        end

        // Fixed select, channel 2
        rst4 = 1'b0;
        sel4 = 2'd2;
        #1;
        check("fix_ready", 32'(ready4), 32'b0100);
        tick();
        check("fix_valid", 32'(ovalid4), 32'h1);
        check("fix_data", 32'(odata4), 32'hA5);
        check("fix_chan", 32'(ochan4), 32'h2);

        // Selected channel idle: no grant, register drains
        sel4   = 2'd1;
        valid4 = 4'b1101;
        #1;
        check("fix_idle_ready", 32'(ready4), 32'h0);
        tick();
        check("fix_idle_valid", 32'(ovalid4), 32'h0);

        // Re-reset so round-robin starts from channel 0
        rst4 = 1'b1;
        tick();
        rst4   = 1'b0;
        mode4  = 1'b1;
        valid4 = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_ready", 32'(ready4), 32'(4'b0001 << (i % 4)));
            tick();
            check("rr_valid", 32'(ovalid4), 32'h1);
            check("rr_chan", 32'(ochan4), 32'(i % 4));
            check("rr_data", 32'(odata4), 32'(exp_data[i % 4]));
        end

        // Sparse valids from ptr=3: 1 then 3,1,3
        valid4   = 4'b1010;
        exp_chan = '{2'd1, 2'd3, 2'd1, 2'd3};
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_sparse_chan", 32'(ochan4), 32'(exp_chan[i]));
            check("rr_sparse_valid", 32'(ovalid4), 32'h1);
        end

        // Load 8'h11 from channel 0, then backpressure for three cycles
        mode4  = 1'b0;
        sel4   = 2'd0;
        valid4 = 4'b0001;
        tick();
        check("bp_load", 32'(odata4), 32'h11);
        mode4   = 1'b1;
        valid4  = 4'b1111;
        oready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready", 32'(ready4), 32'h0);
            tick();
            check("bp_data", 32'(odata4), 32'h11);
            check("bp_valid", 32'(ovalid4), 32'h1);
            check("bp_chan", 32'(ochan4), 32'h0);
        end
        oready4 = 1'b1;
        #1;
        check("bp_rel_ready", 32'(ready4), 32'b0010);
        tick();
        check("bp_rel_valid", 32'(ovalid4), 32'h1);
        check("bp_rel_data", 32'(odata4), 32'h22);

        // Reset while full and stalled
        oready4 = 1'b0;
        rst4    = 1'b1;
        #1;
        check("mrst_ready", 32'(ready4), 32'h0);
        tick();
        check("mrst_valid", 32'(ovalid4), 32'h0);
        rst4    = 1'b0;
        oready4 = 1'b1;
        valid4  = 4'b0110;
        #1;
        check("mrst_grant", 32'(ready4), 32'b0010);
        tick();
        check("mrst_chan", 32'(ochan4), 32'h1);

        // 3-channel instance: out-of-range select and mode switching
        tick();
        check("n3_rst_valid", 32'(ovalid3), 32'h0);
        rst3  = 1'b0;
        mode3 = 1'b1;
        #1;
        check("n3_rr0_ready", 32'(ready3), 32'b001);
        tick();
        check("n3_rr0_chan", 32'(ochan3), 32'h0);
        check("n3_rr0_data", 32'(odata3), 32'h31);
        mode3 = 1'b0;
        sel3  = 2'd3;
        #1;
        check("n3_oor_ready", 32'(ready3), 32'h0);
        tick();
        check("n3_oor_valid", 32'(ovalid3), 32'h0);
        // ptr stayed at 0, so arbitration resumes at 1, 2, then wraps to 0
        mode3 = 1'b1;
        #1;
        check("n3_resume_ready", 32'(ready3), 32'b010);
        tick();
        check("n3_resume_chan", 32'(ochan3), 32'h1);
        check("n3_resume_data", 32'(odata3), 32'h32);
        tick();
        check("n3_next_chan", 32'(ochan3), 32'h2);
        check("n3_next_data", 32'(odata3), 32'h33);
        tick();
        check("n3_wrap_chan", 32'(ochan3), 32'h0);
        check("n3_wrap_valid", 32'(ovalid3), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
